// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 encodings, fault codes and FSM state for dmem_access_ctrl
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE    = 2'b10;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b11;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: selects the addressed lanes of a memory word and sign/zero extends per funct3
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);
    logic [31:0] sh;
    always_comb begin
        sh = word >> {offset, 3'b000};
        data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
               funct3 == F3_BU ? {24'b0, sh[7:0]} :
               funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
               funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: valid/ready data-memory controller with byte/half/word access and fault reporting.
// Defining DMEM_STATS_EN adds stat_loads/stat_stores/stat_faults access counters.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [1:0]        resp_fault_code
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       stat_loads,
    output logic [31:0]       stat_stores,
    output logic [31:0]       stat_faults
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    state_t state, state_nx;
    logic [31:0] mem [DEPTH];
    logic [1:0] cnt, sz, code, lat_off, rd_off;
    logic [2:0] lat_f3, rd_f3;
    logic [IDX_W-1:0] req_idx, lat_idx, rd_idx;
    logic accept, illegal, misalign, out_of_range, fault;
    logic [3:0] be;
    logic [31:0] wd, aligned;

    assign sz = req_funct3[1:0];
    assign req_idx = req_addr[IDX_W+1:2];
    assign accept = req_valid && req_ready;
    assign illegal = req_we ? (req_funct3[2] || sz == 2'b11) : (sz == 2'b11 || req_funct3[2:1] == 2'b11);
    assign misalign = (sz == 2'b01 && req_addr[0]) || (sz == 2'b10 && req_addr[1:0] != 2'b00);
    assign out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
    assign code = illegal ? FLT_ILLEGAL : misalign ? FLT_MISALIGN : out_of_range ? FLT_RANGE : FLT_NONE;
    assign fault = code != FLT_NONE;
    assign be = sz == 2'b00 ? 4'b0001 << req_addr[1:0] : sz == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd = sz == 2'b00 ? {4{req_wdata[7:0]}} : sz == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;

    // Single-cycle loads read straight off the request; longer ones use the captured copy
    assign rd_idx = state == IDLE ? req_idx : lat_idx;
    assign rd_f3 = state == IDLE ? req_funct3 : lat_f3;
    assign rd_off = state == IDLE ? req_addr[1:0] : lat_off;

    dmem_load_align u_align (.word(mem[rd_idx]), .funct3(rd_f3), .offset(rd_off), .data(aligned));

    always_ff @(posedge clk)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (accept ? ((req_we || fault || READ_LAT == 1) ? RESP : WAIT) : IDLE) :
                   state == WAIT ? (cnt == 2'd1 ? RESP : WAIT) :
                   (resp_ready ? IDLE : RESP);

    always_comb begin
        req_ready = state == IDLE;
        resp_valid = state == RESP;
    end

    always_ff @(posedge clk)
        if (!reset_n) begin
            cnt <= '0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            resp_fault_code <= FLT_NONE;
            lat_idx <= '0;
            lat_f3 <= '0;
            lat_off <= '0;
        end else if (accept) begin
            cnt <= 2'(READ_LAT - 1);
            resp_rdata <= (fault || req_we) ? 32'b0 : aligned;
            resp_fault <= fault;
            resp_fault_code <= code;
            lat_idx <= req_idx;
            lat_f3 <= req_funct3;
            lat_off <= req_addr[1:0];
        end else if (state == WAIT) begin
            cnt <= cnt - 2'd1;
            resp_rdata <= aligned;
        end

    always_ff @(posedge clk)
        if (reset_n && accept && req_we && !fault)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[req_idx][8*b +: 8] <= wd[8*b +: 8];

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk)
        if (!reset_n) begin
            stat_loads <= '0;
            stat_stores <= '0;
            stat_faults <= '0;
        end else if (accept) begin
            stat_loads <= stat_loads + 32'(!fault && !req_we);
            stat_stores <= stat_stores + 32'(!fault && req_we);
            stat_faults <= stat_faults + 32'(fault);
        end
`endif
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Parametrised data-memory controller for the MEM stage and the load/store queue.
- Replaces the fixed 256-word, word-only, always-ready memory with a valid/ready request channel and a response channel with backpressure.
- Supports RISC-V byte, half and word accesses (funct3-encoded) with sign/zero extension and byte-lane writes.
- Flags misaligned, out-of-range and illegal-size accesses. Read latency is configurable.

Parameters:
ADDR_W, 32, request byte-address width
DEPTH, 256, number of 32-bit words; power of two, >= 4
READ_LAT, 1, cycles from request accept to read response valid; legal range 1..3
Data width is fixed at 32 bits.

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V size/sign encoding
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer takes the response
resp_rdata  out  32  load result after extension; 0 for stores and faults
resp_fault  out  1  access was rejected
resp_fault_code  out  2  00 none, 01 misaligned, 10 out-of-range, 11 illegal funct3

Behaviour:
- Reset (reset_n low at an edge): state=IDLE, resp_valid=0, resp_rdata=0, resp_fault=0, resp_fault_code=0, latency counter=0. Memory array is not cleared.
- req_ready = (state==IDLE), combinational from state only. Accept = req_valid & req_ready. Only one request is outstanding.
- Word index = req_addr[ADDR_W-1:2]. Out-of-range when the index is >= DEPTH.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Fault priority: illegal > misaligned > out-of-range.
  - Misaligned: half-word access with addr[0]=1, or word access with addr[1:0]!=0.
- FSM:
  - IDLE -> RESP on accept of a store, a faulting request, or a load when READ_LAT=1.
  - IDLE -> WAIT on accept of a load when READ_LAT>1; counter loads READ_LAT-1.
  - WAIT: counter decrements each cycle; -> RESP when it reaches 0.
  - RESP: -> IDLE when resp_ready=1. Otherwise hold with all resp_* outputs stable.
- Store with no fault: byte lanes written at the accept edge.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Response arrives the next cycle with rdata=0.
- Faulting store: no memory write.
- Load: lanes are sampled on the edge entering RESP; latency = READ_LAT cycles after accept. Lanes are selected by addr[1:0] and sign- or zero-extended per funct3.
- Fault response: resp_fault=1, resp_rdata=0, one cycle after accept, independent of READ_LAT.
- resp_valid falls in the cycle after the resp_ready handshake. Minimum issue rate is one request per 2 cycles.
- Reset mid-operation: the in-flight load response is dropped; a store accepted before reset stays committed.

Optional Feature:
- Macro DMEM_STATS_EN adds three outputs: stat_loads, stat_stores, stat_faults, each 32 bits.
- Each counter increments on accept of a non-faulting load, a non-faulting store, or any faulting request respectively.
- Counters wrap at 2^32 and clear on reset.
- Without the macro the ports and counters do not exist and the remaining behaviour is identical.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - fault-code constants (FLT_NONE, FLT_MISALIGN, FLT_RANGE, FLT_ILLEGAL);
  - FSM state typedef (IDLE, WAIT, RESP).
- One sub-module, dmem_load_align: combinational lane select and sign/zero extension from funct3 and addr[1:0].

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 with READ_LAT=2 -> resp_valid exactly 2 cycles after accept, rdata=0xDEADBEEF, fault=0.
- SB 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
- LH 0x11 -> fault=1, code=01, rdata=0; SW 0x12 -> fault, code=01, memory at 0x10 unchanged.
- LW 0x400 with DEPTH=256 -> code=10; funct3=011 -> code=11; SH with funct3=101 -> code=11.
- LW response held with resp_ready=0 for 5 cycles -> resp_valid, rdata and fault stable, req_ready=0 throughout; resp_ready=1 -> IDLE on the next cycle.
- reset_n low during WAIT -> next cycle resp_valid=0 and req_ready=1, no stale response; a prior SW to 0x20 is still readable afterwards.
